// File: rtl/mem_bus_port.sv
// Consumer side of the 16-bit datapath bus: MAR/MDR registers plus the
// multi-cycle SRAM read/write handshake FSM driving active-low strobes.
module mem_bus_port #(
  parameter int ADDR_W     = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       BUS,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              MEM_RD,
  input  logic              MEM_WR,
  input  logic [15:0]       Data_from_SRAM,
  output logic [15:0]       MAR,
  output logic [15:0]       MDR,
  output logic [ADDR_W-1:0] ADDR,
  output logic [15:0]       Data_to_SRAM,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic              R,
  output logic              BUSY
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      mar_q, mar_d;
  logic [15:0]      mdr_q, mdr_d;
  logic [15:0]      rdbuf_q, rdbuf_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;

  // MAR/MDR loads are independent of the handshake FSM.
  always_comb begin
    mar_d = LD_MAR ? BUS : mar_q;
    mdr_d = mdr_q;
    if (LD_MDR) mdr_d = MIO_EN ? rdbuf_q : BUS;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdbuf_d = rdbuf_q;
    CE      = 1'b1;
    OE      = 1'b1;
    WE      = 1'b1;
    UB      = 1'b1;
    LB      = 1'b1;
    R       = 1'b0;
    BUSY    = 1'b1;
    case (state_q)
      IDLE: begin
        BUSY = 1'b0;
        if (MEM_RD || MEM_WR) begin
          addr_d  = mar_q;
          wdata_d = mdr_q;
          if (MEM_RD) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(READ_WAIT - 1);
          end else begin
            state_d = WR_SETUP;
            cnt_d   = '0;
          end
        end
      end
      RD_WAIT: begin
        CE = 1'b0;
        OE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        if (cnt_q == '0) begin
          rdbuf_d = Data_from_SRAM;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        CE      = 1'b0;
        UB      = 1'b0;
        LB      = 1'b0;
        state_d = WR_PULSE;
        cnt_d   = CNT_W'(WRITE_WAIT - 1);
      end
      WR_PULSE: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        WE = 1'b0;
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_HOLD: begin
        CE      = 1'b0;
        UB      = 1'b0;
        LB      = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        R       = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdbuf_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdbuf_q <= rdbuf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The in-flight address is frozen at accept; MAR shows through only when idle.
  assign ADDR         = ADDR_W'(BUSY ? addr_q : mar_q);
  assign Data_to_SRAM = wdata_q;
  assign MAR          = mar_q;
  assign MDR          = mdr_q;

endmodule
